// File: rtl/sha3_pad_block.sv
// SHA3 padding and rate-block framing ahead of cFun: packs 64-bit lanes into 576-bit blocks.
// Define SHA3_PAD_BLKCNT_EN to add the outBlkCnt block-index output.
module sha3_pad_block #(
   parameter int RATE_WORDS = 9,
   parameter int STATE_W    = 1600
) (
   input  logic               inClk,
   input  logic               inRst,
   input  logic [63:0]        inWord,
   input  logic [3:0]         inBytes,
   input  logic               inLast,
   input  logic               inValid,
   output logic               outReady,
   output logic [STATE_W-1:0] outData,
   output logic               outValid,
   output logic               outLast,
`ifdef SHA3_PAD_BLKCNT_EN
   output logic [15:0]        outBlkCnt,
`endif
   input  logic               inAck
);

   localparam int RATE_W     = RATE_WORDS * 64;
   localparam int RATE_BYTES = RATE_WORDS * 8;
   localparam int CNT_W      = $clog2(RATE_WORDS);

   typedef enum logic [1:0] {
      FILL       = 2'd0,
      EMIT       = 2'd1,
      EMIT_EXTRA = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RATE_W-1:0]  buf_q, buf_d;
   logic               last_q, last_d;
   logic               pend_q, pend_d;
   logic               lane_fire;
   logic [63:0]        lane_m;
   logic [3:0]         nb;
   int                 pad_pos;

   assign outReady  = (state_q == FILL) && !inRst;
   assign lane_fire = inValid && outReady;
   assign outValid  = (state_q != FILL);
   assign outLast   = last_q;
   assign outData   = {{(STATE_W-RATE_W){1'b0}}, buf_q};

   always_ff @(posedge inClk) begin
      if (inRst) begin
         state_q <= FILL;
         cnt_q   <= '0;
         buf_q   <= '0;
         last_q  <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         last_q  <= last_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      last_d  = last_q;
      pend_d  = pend_q;
      lane_m  = '0;
      nb      = 4'd8;
      pad_pos = 0;
      case (state_q)
         FILL: begin
            if (lane_fire) begin
               if (inLast) nb = (inBytes > 4'd8) ? 4'd8 : inBytes;
               for (int j = 0; j < 8; j++) begin
                  if (j < int'(nb)) lane_m[8*j +: 8] = inWord[8*j +: 8];
               end
               buf_d[int'(cnt_q)*64 +: 64] = lane_m;
               if (inLast) begin
                  pad_pos = int'(cnt_q) * 8 + int'(nb);
                  cnt_d   = '0;
                  state_d = EMIT;
                  // A message ending exactly on the rate boundary needs a whole extra pad block
                  if (pad_pos < RATE_BYTES) begin
                     buf_d[pad_pos*8 +: 8]   = 8'h06;
                     buf_d[RATE_W-1 -: 8]    = buf_d[RATE_W-1 -: 8] | 8'h80;
                     last_d                  = 1'b1;
                     pend_d                  = 1'b0;
                  end else begin
                     last_d = 1'b0;
                     pend_d = 1'b1;
                  end
               end else if (int'(cnt_q) == RATE_WORDS - 1) begin
                  cnt_d   = '0;
                  state_d = EMIT;
                  last_d  = 1'b0;
                  pend_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         EMIT: begin
            if (inAck) begin
               buf_d = '0;
               if (pend_q) begin
                  buf_d[7:0]           = 8'h06;
                  buf_d[RATE_W-1 -: 8] = 8'h80;
                  pend_d               = 1'b0;
                  last_d               = 1'b1;
                  state_d              = EMIT_EXTRA;
               end else begin
                  last_d  = 1'b0;
                  state_d = FILL;
               end
            end
         end
         EMIT_EXTRA: begin
            if (inAck) begin
               buf_d   = '0;
               last_d  = 1'b0;
               state_d = FILL;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

`ifdef SHA3_PAD_BLKCNT_EN
   logic [15:0] blk_cnt_q, blk_cnt_d;

   assign outBlkCnt = blk_cnt_q;

   always_ff @(posedge inClk) begin
      if (inRst) blk_cnt_q <= '0;
      else       blk_cnt_q <= blk_cnt_d;
   end

   always_comb begin
      blk_cnt_d = blk_cnt_q;
      if (outValid && inAck) begin
         if (last_q)                     blk_cnt_d = '0;
         else if (blk_cnt_q != 16'hFFFF) blk_cnt_d = blk_cnt_q + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sha3_pad_block.sv
// Bench for sha3_pad_block: byte-level SHA3 padding model, randomized lanes, ack delays and resets.
// Honours SHA3_PAD_BLKCNT_EN to also check outBlkCnt.
module tb_sha3_pad_block;

   localparam int RATE_W  = 576;
   localparam int STATE_W = 1600;

   logic               inClk;
   logic               inRst;
   logic [63:0]        inWord;
   logic [3:0]         inBytes;
   logic               inLast;
   logic               inValid;
   logic               outReady;
   logic [STATE_W-1:0] outData;
   logic               outValid;
   logic               outLast;
   logic               inAck;
`ifdef SHA3_PAD_BLKCNT_EN
   logic [15:0]        outBlkCnt;
`endif

   int errors = 0;
   int checks = 0;
   logic [7:0] msg_q [$];

   sha3_pad_block #(.RATE_WORDS(9), .STATE_W(STATE_W)) dut (
      .inClk    (inClk),
      .inRst    (inRst),
      .inWord   (inWord),
      .inBytes  (inBytes),
      .inLast   (inLast),
      .inValid  (inValid),
      .outReady (outReady),
      .outData  (outData),
      .outValid (outValid),
      .outLast  (outLast),
`ifdef SHA3_PAD_BLKCNT_EN
      .outBlkCnt(outBlkCnt),
`endif
      .inAck    (inAck)
   );

   initial inClk = 1'b0;
   always #5 inClk = ~inClk;

   task automatic set_random_msg(input int len);
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
   endtask

   // Sends msg_q as lanes and checks every emitted block against the standard SHA3 pad10*1 layout
   task automatic run_message(input string name, input int ack_max, input bit garbage, input bit extra_empty);
      int len, nlanes, nblocks, lane_idx, blk_idx, wait_cnt, ack_target, cycles, nb;
      logic [7:0] pad [$];
      logic [RATE_W-1:0] exp_blk;
      bit exp_valid, accepted, acked, lane_last;
      len      = msg_q.size();
      nlanes   = (len == 0) ? 1 : (len + 7) / 8;
      if (extra_empty && len > 0 && (len % 8) == 0) nlanes++;
      nblocks  = len / 72 + 1;
      pad.delete();
      for (int i = 0; i < nblocks * 72; i++) pad.push_back((i < len) ? msg_q[i] : 8'h00);
      pad[len]              = 8'h06;
      pad[nblocks * 72 - 1] = pad[nblocks * 72 - 1] | 8'h80;
      lane_idx   = 0;
      blk_idx    = 0;
      wait_cnt   = 0;
      cycles     = 0;
      exp_valid  = 1'b0;
      ack_target = $urandom_range(ack_max, 0);
      while (blk_idx < nblocks) begin
         @(negedge inClk);
         checks++;
         if (outValid !== exp_valid) begin
            errors++;
            $display("[TB] FAIL %s outValid blk%0d lane%0d: got %b expected %b", name, blk_idx, lane_idx, outValid, exp_valid);
         end
         checks++;
         if (outReady !== !exp_valid) begin
            errors++;
            $display("[TB] FAIL %s outReady blk%0d: got %b expected %b", name, blk_idx, outReady, !exp_valid);
         end
         if (exp_valid) begin
            for (int i = 0; i < 72; i++) exp_blk[8*i +: 8] = pad[72 * blk_idx + i];
            checks++;
            if (outData[RATE_W-1:0] !== exp_blk) begin
               errors++;
               $display("[TB] FAIL %s outData blk%0d: got %h expected %h", name, blk_idx, outData[RATE_W-1:0], exp_blk);
            end
            checks++;
            if (outData[STATE_W-1:RATE_W] !== '0) begin
               errors++;
               $display("[TB] FAIL %s outData upper blk%0d: got nonzero expected 0", name, blk_idx);
            end
            checks++;
            if (outLast !== (blk_idx == nblocks - 1)) begin
               errors++;
               $display("[TB] FAIL %s outLast blk%0d: got %b expected %b", name, blk_idx, outLast, (blk_idx == nblocks - 1));
            end
`ifdef SHA3_PAD_BLKCNT_EN
            checks++;
            if (outBlkCnt !== 16'(blk_idx)) begin
               errors++;
               $display("[TB] FAIL %s outBlkCnt: got %0d expected %0d", name, outBlkCnt, blk_idx);
            end
`endif
         end
         inValid = 1'b0;
         inAck   = 1'b0;
         inLast  = 1'b0;
         inBytes = 4'd0;
         inWord  = 64'd0;
         if (lane_idx < nlanes && !(garbage && ($urandom % 4) == 0)) begin
            nb        = len - 8 * lane_idx;
            nb        = (nb < 0) ? 0 : ((nb > 8) ? 8 : nb);
            lane_last = (lane_idx == nlanes - 1);
            for (int j = 0; j < 8; j++)
               inWord[8*j +: 8] = (j < nb) ? msg_q[8 * lane_idx + j] : (garbage ? 8'($urandom) : 8'h00);
            if (lane_last) inBytes = (nb == 8 && garbage) ? 4'($urandom_range(15, 8)) : 4'(nb);
            else           inBytes = garbage ? 4'($urandom_range(15, 0)) : 4'd8;
            inLast  = lane_last;
            inValid = 1'b1;
         end
         if (exp_valid) begin
            if (wait_cnt >= ack_target) inAck = 1'b1;
            else wait_cnt++;
         end else begin
            inAck = garbage ? 1'($urandom % 2) : 1'b0;
         end
         accepted = inValid && !exp_valid;
         acked    = inAck && exp_valid;
         @(posedge inClk);
         if (accepted) begin
            if (inLast || ((lane_idx + 1) % 9) == 0) exp_valid = 1'b1;
            lane_idx++;
         end
         if (acked) begin
            blk_idx++;
            wait_cnt   = 0;
            ack_target = $urandom_range(ack_max, 0);
            exp_valid  = (blk_idx < nblocks) && (lane_idx == nlanes);
         end
         cycles++;
         if (cycles > 3000) begin
            errors++;
            $display("[TB] FAIL %s timeout: got %0d blocks expected %0d", name, blk_idx, nblocks);
            break;
         end
      end
      @(negedge inClk);
      inValid = 1'b0;
      inAck   = 1'b0;
      inLast  = 1'b0;
      checks++;
      if (outValid !== 1'b0 || outReady !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s idle after message: got valid=%b ready=%b expected valid=0 ready=1", name, outValid, outReady);
      end
`ifdef SHA3_PAD_BLKCNT_EN
      checks++;
      if (outBlkCnt !== 16'd0) begin
         errors++;
         $display("[TB] FAIL %s outBlkCnt after last: got %0d expected 0", name, outBlkCnt);
      end
`endif
   endtask

   task automatic test_reset();
      repeat (3) @(posedge inClk);
      @(negedge inClk);
      checks++;
      if (outValid !== 1'b0 || outLast !== 1'b0 || outReady !== 1'b0 || outData !== '0) begin
         errors++;
         $display("[TB] FAIL reset state: got valid=%b last=%b ready=%b data_nonzero=%b expected 0/0/0/0",
                  outValid, outLast, outReady, (outData != '0));
      end
      inRst = 1'b0;
      @(negedge inClk);
      checks++;
      if (outReady !== 1'b1 || outValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL release reset: got ready=%b valid=%b expected 1/0", outReady, outValid);
      end
   endtask

   task automatic test_empty();
      set_random_msg(0);
      run_message("empty", 0, 1'b0, 1'b0);
   endtask

   task automatic test_abc();
      msg_q = '{8'h61, 8'h62, 8'h63};
      run_message("abc", 0, 1'b0, 1'b0);
   endtask

   task automatic test_boundaries();
      set_random_msg(71);
      run_message("len71", 1, 1'b0, 1'b0);
      set_random_msg(72);
      run_message("len72", 1, 1'b0, 1'b0);
      set_random_msg(72);
      run_message("len72_emptylast", 1, 1'b0, 1'b1);
      set_random_msg(144);
      run_message("len144", 2, 1'b1, 1'b0);
   endtask

   task automatic test_backpressure();
      set_random_msg(100);
      run_message("backpressure", 5, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midfill();
      for (int i = 0; i < 4; i++) begin
         @(negedge inClk);
         inWord  = {$urandom, $urandom};
         inBytes = 4'd8;
         inLast  = 1'b0;
         inValid = 1'b1;
      end
      @(negedge inClk);
      inValid = 1'b0;
      inRst   = 1'b1;
      @(negedge inClk);
      checks++;
      if (outValid !== 1'b0 || outData !== '0 || outLast !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset midfill: got valid=%b last=%b data_nonzero=%b expected 0/0/0",
                  outValid, outLast, (outData != '0));
      end
      inRst = 1'b0;
      msg_q = '{8'h61, 8'h62, 8'h63};
      run_message("abc_after_reset", 0, 1'b0, 1'b0);
      // Drive one full non-last block, then reset while it is being offered
      for (int i = 0; i < 9; i++) begin
         @(negedge inClk);
         inWord  = {$urandom, $urandom};
         inBytes = 4'd8;
         inLast  = 1'b0;
         inValid = 1'b1;
      end
      @(negedge inClk);
      inValid = 1'b0;
      checks++;
      if (outValid !== 1'b1 || outLast !== 1'b0) begin
         errors++;
         $display("[TB] FAIL full block before reset: got valid=%b last=%b expected 1/0", outValid, outLast);
      end
      inRst = 1'b1;
      @(negedge inClk);
      checks++;
      if (outValid !== 1'b0 || outData !== '0 || outLast !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset mid-emit: got valid=%b last=%b data_nonzero=%b expected 0/0/0",
                  outValid, outLast, (outData != '0));
      end
`ifdef SHA3_PAD_BLKCNT_EN
      checks++;
      if (outBlkCnt !== 16'd0) begin
         errors++;
         $display("[TB] FAIL reset outBlkCnt: got %0d expected 0", outBlkCnt);
      end
`endif
      inRst = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int m = 0; m < 3; m++) begin
         set_random_msg($urandom_range(80, 1));
         run_message("back_to_back", 0, 1'b0, 1'b0);
      end
   endtask

   task automatic test_random();
      int len;
      for (int m = 0; m < 20; m++) begin
         len = $urandom_range(220, 0);
         set_random_msg(len);
         run_message("random", $urandom_range(4, 0), 1'b1, 1'($urandom % 2));
      end
   endtask

   initial begin
      inRst   = 1'b1;
      inWord  = 64'd0;
      inBytes = 4'd0;
      inLast  = 1'b0;
      inValid = 1'b0;
      inAck   = 1'b0;
      test_reset();
      test_empty();
      test_abc();
      test_boundaries();
      test_backpressure();
      test_reset_midfill();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
